// File: rtl/rgb2raw.sv
// -----------------------------------------------------------------------------
// rgb2raw
//   Re-mosaics a parallel RGB video stream into a Bayer raw stream (inverse of
//   raw2rgb). Each accepted input beat carries IN_PCNT RGB pixels; one colour
//   sample per pixel is kept according to PATTERN and the line/column parity.
//   Two consecutive beats are packed into one OUT_PCNT-pixel raw word.
//
//   Pipeline: stage 1 selects the colour samples and tags the beat with its
//   phase and column; stage 2 is a 2:1 gearbox that holds the first half and
//   emits {hi, lo} on the second half. Syncs travel through the same two
//   register stages, so every output is the input delayed exactly 2 cycles.
//
// Ports
//   i_pclk                      pixel clock, rising edge
//   i_rstn                      synchronous active-low reset
//   i_vsync, i_hsync, i_de      input syncs / data enable
//   i_valid                     input beat qualifier (ignored when i_de = 0)
//   i_r, i_g, i_b               IN_PCNT pixels, pixel k at [k*PW +: PW]
//   o_vsync, o_hsync, o_de      input syncs delayed 2 cycles
//   o_valid                     o_raw qualifier
//   o_raw                       OUT_PCNT raw pixels, pixel j at [j*PW +: PW]
//   o_x_cnt                     column of o_raw pixel 0
//   o_y_cnt                     line index aligned with o_de
//   o_line_err                  sticky: a line ended with an odd beat count
// -----------------------------------------------------------------------------
module rgb2raw #(
  parameter int          PW        = 8,
  parameter int          IN_PCNT   = 2,
  parameter int          OUT_PCNT  = 4,
  parameter int          MAX_HRES  = 3840,
  parameter int          MAX_VRES  = 2160,
  parameter logic [31:0] PATTERN   = "GBRG",
  localparam int         X_ACT_WID = $clog2(MAX_HRES),
  localparam int         Y_ACT_WID = $clog2(MAX_VRES)
) (
  input  logic                    i_pclk,
  input  logic                    i_rstn,
  input  logic                    i_vsync,
  input  logic                    i_hsync,
  input  logic                    i_de,
  input  logic                    i_valid,
  input  logic [PW*IN_PCNT-1:0]   i_r,
  input  logic [PW*IN_PCNT-1:0]   i_g,
  input  logic [PW*IN_PCNT-1:0]   i_b,
  output logic                    o_vsync,
  output logic                    o_hsync,
  output logic                    o_de,
  output logic                    o_valid,
  output logic [PW*OUT_PCNT-1:0]  o_raw,
  output logic [X_ACT_WID-1:0]    o_x_cnt,
  output logic [Y_ACT_WID-1:0]    o_y_cnt,
  output logic                    o_line_err
);

  // ---------------------------------------------------------------------------
  // Elaboration checks
  // ---------------------------------------------------------------------------
  localparam bit PATTERN_OK = (PATTERN == "RGGB") || (PATTERN == "GRBG") ||
                              (PATTERN == "GBRG") || (PATTERN == "BGGR");

  if ((IN_PCNT % 2) != 0) begin : g_bad_in_pcnt
    $error("rgb2raw: IN_PCNT must be even");
  end
  if (OUT_PCNT != 2 * IN_PCNT) begin : g_bad_out_pcnt
    $error("rgb2raw: OUT_PCNT must equal 2*IN_PCNT");
  end
  if (!PATTERN_OK) begin : g_bad_pattern
    $error("rgb2raw: PATTERN must be RGGB, GRBG, GBRG or BGGR");
  end

  // ---------------------------------------------------------------------------
  // Colour selection table derived from PATTERN
  //   chars 1-2: even row, even/odd column; chars 3-4: odd row.
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    COL_R = 2'd0,
    COL_G = 2'd1,
    COL_B = 2'd2
  } colour_e;

  function automatic colour_e char_colour(input logic [7:0] c);
    case (c)
      "R":     return COL_R;
      "B":     return COL_B;
      default: return COL_G;
    endcase
  endfunction

  localparam colour_e SEL_E0 = char_colour(PATTERN[31:24]);
  localparam colour_e SEL_E1 = char_colour(PATTERN[23:16]);
  localparam colour_e SEL_O0 = char_colour(PATTERN[15:8]);
  localparam colour_e SEL_O1 = char_colour(PATTERN[7:0]);

  // ---------------------------------------------------------------------------
  // Input-side state
  // ---------------------------------------------------------------------------
  logic                   vs_d, hs_d, de_d;   // stage-1 syncs, also edge history
  logic                   phase;              // 0: next beat is the low half
  logic [X_ACT_WID-1:0]   col_cnt;            // column of the next beat
  logic [Y_ACT_WID-1:0]   y_cnt;

  logic                   vs_rise, de_rise, de_fall, accept;
  logic [X_ACT_WID-1:0]   beat_col;
  logic [PW*IN_PCNT-1:0]  raw_beat;

  assign vs_rise = i_vsync & ~vs_d;
  assign de_rise = i_de & ~de_d;
  assign de_fall = ~i_de & de_d;

  // A vsync rise restarts the frame; a beat landing in that same cycle is
  // dropped so the new frame always starts on a clean phase-0 boundary.
  assign accept   = i_de & i_valid & ~vs_rise;
  assign beat_col = de_rise ? '0 : col_cnt;

  // Per-pixel colour pick. Because IN_PCNT is even, pixel k's column parity
  // is simply k[0].
  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned, which would otherwise infer a latch.
  always_comb begin : p_mosaic
    colour_e sel;
    raw_beat = '0;
    sel      = COL_G;
    for (int k = 0; k < IN_PCNT; k++) begin
      if (y_cnt[0]) sel = ((k % 2) == 1) ? SEL_O1 : SEL_O0;
      else          sel = ((k % 2) == 1) ? SEL_E1 : SEL_E0;
      case (sel)
        COL_R:   raw_beat[k*PW +: PW] = i_r[k*PW +: PW];
        COL_G:   raw_beat[k*PW +: PW] = i_g[k*PW +: PW];
        default: raw_beat[k*PW +: PW] = i_b[k*PW +: PW];
      endcase
    end
  end

  // Frame tracking: phase, column, line and the sticky odd-beat flag.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_pclk) begin
    if (!i_rstn) begin
      phase      <= 1'b0;
      col_cnt    <= '0;
      y_cnt      <= '0;
      o_line_err <= 1'b0;
    end else begin
      if (vs_rise || de_fall) phase <= 1'b0;
      else if (accept)        phase <= ~phase;

      if (accept)                  col_cnt <= beat_col + X_ACT_WID'(IN_PCNT);
      else if (de_rise || vs_rise) col_cnt <= '0;

      if (vs_rise)
        y_cnt <= '0;
      else if (de_fall && (y_cnt != Y_ACT_WID'(MAX_VRES - 1)))
        y_cnt <= y_cnt + Y_ACT_WID'(1);

      // A pending low half at end of line is simply abandoned; phase is
      // cleared above, so only the flag records it.
      if (vs_rise)              o_line_err <= 1'b0;
      else if (de_fall && phase) o_line_err <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1 registers
  // ---------------------------------------------------------------------------
  logic                   s1_valid, s1_phase, s1_flush;
  logic [PW*IN_PCNT-1:0]  s1_raw;
  logic [X_ACT_WID-1:0]   s1_col;
  logic [Y_ACT_WID-1:0]   s1_y;

  // NOTE: the data registers are reset along with control because the block
  // guarantees an all-zero output state straight out of reset.
  always_ff @(posedge i_pclk) begin
    if (!i_rstn) begin
      vs_d     <= 1'b0;
      hs_d     <= 1'b0;
      de_d     <= 1'b0;
      s1_valid <= 1'b0;
      s1_phase <= 1'b0;
      s1_flush <= 1'b0;
      s1_raw   <= '0;
      s1_col   <= '0;
      s1_y     <= '0;
    end else begin
      vs_d     <= i_vsync;
      hs_d     <= i_hsync;
      de_d     <= i_de;
      s1_valid <= accept;
      s1_flush <= vs_rise;
      s1_y     <= y_cnt;
      if (accept) begin
        s1_raw   <= raw_beat;
        s1_phase <= phase;
        s1_col   <= beat_col;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: gearbox and output registers
  // ---------------------------------------------------------------------------
  logic [PW*IN_PCNT-1:0]  lo;
  logic [X_ACT_WID-1:0]   lo_col;

  always_ff @(posedge i_pclk) begin
    if (!i_rstn) begin
      o_vsync <= 1'b0;
      o_hsync <= 1'b0;
      o_de    <= 1'b0;
      o_valid <= 1'b0;
      o_raw   <= '0;
      o_x_cnt <= '0;
      o_y_cnt <= '0;
      lo      <= '0;
      lo_col  <= '0;
    end else begin
      o_vsync <= vs_d;
      o_hsync <= hs_d;
      o_de    <= de_d;
      o_y_cnt <= s1_y;
      o_valid <= s1_valid & s1_phase;

      // The flush marker trails the last pre-vsync beat by one cycle, so the
      // stale half captured just before it is wiped here.
      if (s1_flush) begin
        lo     <= '0;
        lo_col <= '0;
      end else if (s1_valid && !s1_phase) begin
        lo     <= s1_raw;
        lo_col <= s1_col;
      end

      if (s1_valid && s1_phase) begin
        o_raw   <= {s1_raw, lo};
        o_x_cnt <= lo_col;
      end
    end
  end

endmodule

// File: tb/tb_rgb2raw.sv
// -----------------------------------------------------------------------------
// tb_rgb2raw
//   Drives two rgb2raw instances (GBRG and RGGB) with the same stream.
//   Expected raw words come from a pixel-level model: the colour of each
//   output pixel is looked up from PATTERN by (row parity, column parity).
//   Stimulus pushes expected words into per-instance queues; a monitor on the
//   falling edge pops and compares whenever o_valid is seen.
// -----------------------------------------------------------------------------
module tb_rgb2raw;

  localparam int PW = 8;
  localparam int IW = 16;   // PW * IN_PCNT
  localparam int OW = 32;   // PW * OUT_PCNT
  localparam int XW = 12;
  localparam int YW = 12;
  localparam logic [31:0] PAT [2] = '{"GBRG", "RGGB"};

  typedef struct {
    logic [OW-1:0] raw;
    int            x;
    int            y;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn;
  logic          vsync, hsync, de, valid;
  logic [IW-1:0] r, g, b;

  logic [1:0]    o_vsync, o_hsync, o_de, o_valid, o_line_err;
  logic [OW-1:0] o_raw [2];
  logic [XW-1:0] o_x   [2];
  logic [YW-1:0] o_y   [2];

  rgb2raw #(.PATTERN("GBRG")) u_dut_gbrg (
    .i_pclk(clk), .i_rstn(rstn), .i_vsync(vsync), .i_hsync(hsync), .i_de(de),
    .i_valid(valid), .i_r(r), .i_g(g), .i_b(b),
    .o_vsync(o_vsync[0]), .o_hsync(o_hsync[0]), .o_de(o_de[0]),
    .o_valid(o_valid[0]), .o_raw(o_raw[0]), .o_x_cnt(o_x[0]),
    .o_y_cnt(o_y[0]), .o_line_err(o_line_err[0])
  );

  rgb2raw #(.PATTERN("RGGB")) u_dut_rggb (
    .i_pclk(clk), .i_rstn(rstn), .i_vsync(vsync), .i_hsync(hsync), .i_de(de),
    .i_valid(valid), .i_r(r), .i_g(g), .i_b(b),
    .o_vsync(o_vsync[1]), .o_hsync(o_hsync[1]), .o_de(o_de[1]),
    .o_valid(o_valid[1]), .o_raw(o_raw[1]), .o_x_cnt(o_x[1]),
    .o_y_cnt(o_y[1]), .o_line_err(o_line_err[1])
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int            n_checks = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  bit            sb_en    = 1'b0;
  bit            sync_en  = 1'b0;
  exp_t          sb_q [2][$];
  int            valid_cnt [2];
  logic [OW-1:0] last_raw  [2];
  int            last_x    [2];

  // Reference-model state
  int            row, col, lo_col;
  bit            half;
  logic [IW-1:0] lo_r, lo_g, lo_b;
  logic [IW-1:0] dat_r [240], dat_g [240], dat_b [240];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Bayer colour of pixel (row, c) is PATTERN char index (row%2)*2 + c%2.
  function automatic logic [OW-1:0] model_word(
      input logic [31:0] pat, input int y, input int x,
      input logic [IW-1:0] r0, g0, b0, r1, g1, b1);
    logic [OW-1:0] w;
    logic [7:0]    ch, pr, pg, pb;
    int            idx;
    w = '0;
    for (int j = 0; j < 4; j++) begin
      idx = (y % 2) * 2 + ((x + j) % 2);
      ch  = pat[31 - 8*idx -: 8];
      pr  = (j < 2) ? r0[8*j +: 8] : r1[8*(j-2) +: 8];
      pg  = (j < 2) ? g0[8*j +: 8] : g1[8*(j-2) +: 8];
      pb  = (j < 2) ? b0[8*j +: 8] : b1[8*(j-2) +: 8];
      if (ch == "R")      w[8*j +: 8] = pr;
      else if (ch == "G") w[8*j +: 8] = pg;
      else                w[8*j +: 8] = pb;
    end
    return w;
  endfunction

  function automatic logic [63:0] all_outs(input int d);
    return {3'b0, o_vsync[d], o_hsync[d], o_de[d], o_valid[d], o_line_err[d],
            o_raw[d], o_x[d], o_y[d]};
  endfunction

  // ---------------------------------------------------------------------------
  // Cycle counter and monitor
  // ---------------------------------------------------------------------------
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin : monitor
    exp_t       e;
    logic [2:0] h1, h2;
    h1 = '0;
    h2 = '0;
    forever begin
      @(negedge clk);
      if (sync_en) begin
        for (int d = 0; d < 2; d++)
          check($sformatf("sync_delay[%0d]", d), {o_vsync[d], o_hsync[d], o_de[d]}, h2);
      end
      h2 = h1;
      h1 = {vsync, hsync, de};
      if (sb_en) begin
        for (int d = 0; d < 2; d++) begin
          if (o_valid[d]) begin
            valid_cnt[d]++;
            last_raw[d] = o_raw[d];
            last_x[d]   = int'(o_x[d]);
            if (sb_q[d].size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL sb_unexpected[%0d]: got o_valid=1 raw=0x%0h, required no word", d, o_raw[d]);
            end else begin
              e = sb_q[d].pop_front();
              check($sformatf("raw[%0d]", d),     o_raw[d], e.raw);
              check($sformatf("x_cnt[%0d]", d),   o_x[d], e.x);
              check($sformatf("y_cnt[%0d]", d),   o_y[d], e.y);
              check($sformatf("latency[%0d]", d), cyc, e.cyc + 2);
              check($sformatf("valid_de[%0d]", d), o_de[d], 1);
            end
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    vsync = 1'b0; hsync = 1'b0; de = 1'b0; valid = 1'b0;
  endtask

  task automatic beat(input logic [IW-1:0] br, bg, bb);
    valid = 1'b1; r = br; g = bg; b = bb;
    if (!half) begin
      lo_r = br; lo_g = bg; lo_b = bb; lo_col = col; half = 1'b1;
    end else begin
      for (int d = 0; d < 2; d++)
        sb_q[d].push_back('{model_word(PAT[d], row, lo_col, lo_r, lo_g, lo_b, br, bg, bb),
                            lo_col, row, cyc});
      half = 1'b0;
    end
    col += 2;
    tick();
  endtask

  // vsync rise restarts the frame: line 0, column 0, partial word dropped.
  task automatic vsync_pulse();
    valid = 1'b0;
    vsync = 1'b1;
    row = 0; col = 0; half = 1'b0;
    tick(); tick();
    vsync = 1'b0;
    repeat (4) tick();
  endtask

  task automatic line_start();
    hsync = 1'b1; tick();
    hsync = 1'b0; tick();
    de = 1'b1; col = 0;
  endtask

  task automatic line_end();
    valid = 1'b0; de = 1'b0;
    half = 1'b0; row++;
    repeat (4) tick();
  endtask

  task automatic send_line(input int nbeats, input int gap, input bit use_const);
    line_start();
    for (int i = 0; i < nbeats; i++) begin
      repeat (gap - 1) begin
        valid = 1'b0; r = IW'($urandom); g = IW'($urandom); b = IW'($urandom);
        tick();
      end
      if (use_const) beat(16'h1111, 16'h2222, 16'h3333);
      else           beat(dat_r[i], dat_g[i], dat_b[i]);
    end
    line_end();
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int v0 [2];
    rstn = 1'b0;
    idle();
    r = '0; g = '0; b = '0;
    row = 0; col = 0; lo_col = 0; half = 1'b0;
    lo_r = '0; lo_g = '0; lo_b = '0;
    for (int d = 0; d < 2; d++) begin
      valid_cnt[d] = 0; last_raw[d] = '0; last_x[d] = -1;
    end
    for (int i = 0; i < 240; i++) begin
      dat_r[i] = IW'($urandom); dat_g[i] = IW'($urandom); dat_b[i] = IW'($urandom);
    end

    // Reset held for 5 cycles with toggling inputs
    repeat (5) begin
      vsync = 1'($urandom); hsync = 1'($urandom); de = 1'($urandom); valid = 1'b1;
      r = IW'($urandom); g = IW'($urandom); b = IW'($urandom);
      tick();
      for (int d = 0; d < 2; d++) check($sformatf("reset_outputs[%0d]", d), all_outs(d), 64'd0);
    end
    rstn = 1'b1;
    idle();
    tick();
    for (int d = 0; d < 2; d++) check($sformatf("post_reset_outputs[%0d]", d), all_outs(d), 64'd0);
    sb_en = 1'b1;
    repeat (3) tick();
    sync_en = 1'b1;

    // Pattern mapping with constant colours
    vsync_pulse();
    send_line(2, 1, 1'b1);
    check("gbrg_row0", last_raw[0], 32'h33223322);
    check("rggb_row0", last_raw[1], 32'h22112211);
    send_line(2, 1, 1'b1);
    check("gbrg_row1", last_raw[0], 32'h22112211);
    check("rggb_row1", last_raw[1], 32'h33223322);

    // Continuous 480-pixel line
    vsync_pulse();
    v0[0] = valid_cnt[0];
    send_line(240, 1, 1'b0);
    check("cont_word_count", valid_cnt[0] - v0[0], 120);
    check("cont_last_x", last_x[0], 476);

    // Same line with a beat every third cycle
    vsync_pulse();
    v0[0] = valid_cnt[0];
    send_line(240, 3, 1'b0);
    check("gap_word_count", valid_cnt[0] - v0[0], 120);
    check("gap_last_x", last_x[0], 476);

    // Odd beat count
    vsync_pulse();
    check("line_err_clear_before", o_line_err, 2'b00);
    v0[0] = valid_cnt[0];
    send_line(3, 1, 1'b0);
    check("odd_word_count", valid_cnt[0] - v0[0], 1);
    check("line_err_set", o_line_err, 2'b11);
    repeat (10) tick();
    check("line_err_sticky", o_line_err, 2'b11);
    vsync_pulse();
    check("line_err_cleared", o_line_err, 2'b00);

    // Vertical tracking over 4 lines
    vsync_pulse();
    for (int l = 0; l < 4; l++) send_line(4, 1, 1'b0);
    for (int d = 0; d < 2; d++) check($sformatf("y_after_4_lines[%0d]", d), o_y[d], row);

    // vsync rise in the middle of a line, with a low half pending
    line_start();
    beat(dat_r[0], dat_g[0], dat_b[0]);
    valid = 1'b0;
    tick();
    vsync_pulse();
    for (int d = 0; d < 2; d++) check($sformatf("y_after_midline_vsync[%0d]", d), o_y[d], 0);
    beat(16'h1111, 16'h2222, 16'h3333);
    beat(16'h1111, 16'h2222, 16'h3333);
    line_end();
    check("midline_gbrg_even", last_raw[0], 32'h33223322);
    check("midline_rggb_even", last_raw[1], 32'h22112211);
    check("midline_x0", last_x[0], 0);
    check("midline_line_err", o_line_err, 2'b00);

    repeat (10) tick();
    for (int d = 0; d < 2; d++) check($sformatf("sb_drained[%0d]", d), sb_q[d].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
